// File: rtl/fir_conv_tdm_pkg.sv
// fir_conv_pkg: shared state type, width helpers and output scaling
// for the time-multiplexed FIR convolver.
package fir_conv_pkg;

   typedef enum logic [1:0] {
      CLEAR,
      IDLE,
      ACCUM,
      ROUND
   } state_t;

   function automatic int cyc_per_sample(int taps, int lanes);
      return taps / lanes;
   endfunction

   function automatic int lane_acc_w(int fxp, int taps, int lanes);
      return 2 * fxp + $clog2(taps / lanes);
   endfunction

   function automatic int sum_w(int fxp, int taps);
      return 2 * fxp + $clog2(taps);
   endfunction

   // Floor shift (arithmetic >>>) then clamp to the signed fxp range.
   function automatic logic signed [63:0] sat_shift(
      logic signed [63:0] v,
      int                 frac,
      int                 fxp
   );
      logic signed [63:0] s;
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      s  = v >>> frac;
      hi = (64'sd1 <<< (fxp - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (fxp - 1));
      if (s > hi) return hi;
      if (s < lo) return lo;
      return s;
   endfunction

endpackage

// File: rtl/fir_conv_tdm_if.sv
// fir_conv_tdm_if: sample, IR-write and result signals of the convolver.
// master drives samples/coefficients, slave is the convolver.
interface fir_conv_tdm_if #(
   parameter int fxp_size    = 16,
   parameter int window_size = 256
);
   localparam int AW = $clog2(window_size);

   logic signed [fxp_size-1:0] i_data;
   logic                       i_valid;
   logic                       o_ready;
   logic                       i_bypass;
   logic                       i_ir_wr_en;
   logic [AW-1:0]              i_ir_wr_addr;
   logic signed [fxp_size-1:0] i_ir_wr_data;
   logic signed [fxp_size-1:0] o_data;
   logic                       o_valid;
   logic                       o_overrun;

   modport master (
      output i_data, i_valid, i_bypass,
      output i_ir_wr_en, i_ir_wr_addr, i_ir_wr_data,
      input  o_ready, o_data, o_valid, o_overrun
   );

   modport slave (
      input  i_data, i_valid, i_bypass,
      input  i_ir_wr_en, i_ir_wr_addr, i_ir_wr_data,
      output o_ready, o_data, o_valid, o_overrun
   );

endinterface

// File: rtl/fir_conv_tdm_mac_lane.sv
// fir_mac_lane: one history bank, one IR bank and one accumulator.
// Banks read combinationally so every lane issues one MAC per clock.
module fir_mac_lane #(
   parameter int fxp_size = 16,
   parameter int depth    = 64,
   parameter int acc_w    = 38
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       hist_we,
   input  logic [$clog2(depth)-1:0]   hist_waddr,
   input  logic signed [fxp_size-1:0] hist_wdata,
   input  logic [$clog2(depth)-1:0]   hist_raddr,
   output logic signed [fxp_size-1:0] hist_rdata,
   input  logic                       ir_we,
   input  logic [$clog2(depth)-1:0]   ir_waddr,
   input  logic signed [fxp_size-1:0] ir_wdata,
   input  logic [$clog2(depth)-1:0]   ir_raddr,
   input  logic signed [fxp_size-1:0] x,
   input  logic                       acc_clr,
   input  logic                       acc_en,
   output logic signed [acc_w-1:0]    acc
);
   localparam int PW = 2 * fxp_size;

   logic signed [fxp_size-1:0] hist_mem [depth];
   logic signed [fxp_size-1:0] ir_mem   [depth];
   logic signed [fxp_size-1:0] h;
   logic signed [PW-1:0]       prod;

   // Storage only; IR contents survive reset.
   always_ff @(posedge clk) begin
      if (hist_we) hist_mem[hist_waddr] <= hist_wdata;
      if (ir_we) ir_mem[ir_waddr] <= ir_wdata;
   end

   assign hist_rdata = hist_mem[hist_raddr];
   assign h          = ir_mem[ir_raddr];
   assign prod       = PW'(h) * PW'(x);

   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (acc_clr) begin
         acc <= '0;
      end else if (acc_en) begin
         acc <= acc + acc_w'(prod);
      end
   end

endmodule

// File: rtl/fir_conv_tdm.sv
// fir_conv_tdm: time-multiplexed direct-form FIR convolver with
// loadable IR, circular history, bypass and ready/valid input.
module fir_conv_tdm
   import fir_conv_pkg::*;
#(
   parameter int fxp_size    = 16,
   parameter int frac_size   = 12,
   parameter int window_size = 256,
   parameter int lanes       = 4
) (
   input logic           clk,
   input logic           rst,
   fir_conv_tdm_if.slave bus
);
   localparam int D   = cyc_per_sample(window_size, lanes);
   localparam int DW  = $clog2(D);
   localparam int AW  = $clog2(window_size);
   localparam int LW  = $clog2(lanes);
   localparam int ACW = lane_acc_w(fxp_size, window_size, lanes);
   localparam int SW  = sum_w(fxp_size, window_size);
   localparam logic [DW-1:0] LAST = DW'(D - 1);

   state_t                     state_q;
   state_t                     state_d;
   logic [DW-1:0]              cnt_q;
   logic [DW-1:0]              cnt_d;
   logic [AW-1:0]              wr_ptr_q;
   logic                       byp_q;
   logic signed [fxp_size-1:0] x_q;
   logic                       rnd_q;
   logic signed [SW-1:0]       sum_q;
   logic signed [fxp_size-1:0] o_data_q;
   logic                       o_valid_q;
   logic                       ovr_q;

   logic ready;
   logic accept;
   logic ir_we;
   logic acc_clr;
   logic acc_en;
   logic hist_clr;
   logic rnd;

   logic [DW-1:0]              hist_waddr;
   logic signed [fxp_size-1:0] hist_wdata;
   logic [LW-1:0]              hist_wbank;
   logic [LW-1:0]              ir_wbank;
   logic [AW-1:0]              rd_idx;
   logic [LW-1:0]              rd_bank;
   logic signed [SW-1:0]       sum;

   logic signed [fxp_size-1:0] hist_rd [lanes];
   logic signed [fxp_size-1:0] x_op    [lanes];
   logic signed [ACW-1:0]      acc     [lanes];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ready    = 1'b0;
      accept   = 1'b0;
      ir_we    = 1'b0;
      acc_clr  = 1'b0;
      acc_en   = 1'b0;
      hist_clr = 1'b0;
      rnd      = 1'b0;
      unique case (state_q)
         CLEAR: begin
            hist_clr = 1'b1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = IDLE;
         end
         IDLE: begin
            ready = 1'b1;
            ir_we = bus.i_ir_wr_en;
            if (bus.i_valid) begin
               accept  = 1'b1;
               acc_clr = 1'b1;
               cnt_d   = '0;
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            acc_en = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = ROUND;
         end
         ROUND: begin
            rnd     = 1'b1;
            state_d = IDLE;
         end
         default: state_d = CLEAR;
      endcase
   end

   // Sum is registered in ROUND; the scaled result lands one clock later.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CLEAR;
         cnt_q     <= '0;
         wr_ptr_q  <= '0;
         byp_q     <= 1'b0;
         x_q       <= '0;
         rnd_q     <= 1'b0;
         sum_q     <= '0;
         o_data_q  <= '0;
         o_valid_q <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rnd_q     <= rnd;
         o_valid_q <= rnd_q;
         if (accept) begin
            byp_q <= bus.i_bypass;
            x_q   <= bus.i_data;
         end
         if (rnd) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            sum_q    <= sum;
         end
         if (rnd_q) begin
            o_data_q <= byp_q ? x_q :
               fxp_size'(sat_shift(64'(sum_q), frac_size, fxp_size));
         end
         if (!ready && (bus.i_valid || bus.i_ir_wr_en)) ovr_q <= 1'b1;
      end
   end

   assign hist_waddr = hist_clr ? cnt_q : wr_ptr_q[DW-1:0];
   assign hist_wdata = hist_clr ? '0 : bus.i_data;
   assign hist_wbank = wr_ptr_q[AW-1:DW];
   assign ir_wbank   = bus.i_ir_wr_addr[AW-1:DW];

   // Taps l*D+j share one bank address; the bank index rotates per lane.
   assign rd_idx  = wr_ptr_q - AW'(cnt_q);
   assign rd_bank = rd_idx[AW-1:DW];

   for (genvar l = 0; l < lanes; l++) begin : g_lane
      localparam logic [LW-1:0] LID = LW'(l);
      logic [LW-1:0] sel;
      logic          h_we;
      logic          c_we;

      assign sel     = rd_bank - LID;
      assign x_op[l] = hist_rd[sel];
      assign h_we    = !rst && (hist_clr || (accept && hist_wbank == LID));
      assign c_we    = !rst && ir_we && ir_wbank == LID;

      fir_mac_lane #(
         .fxp_size (fxp_size),
         .depth    (D),
         .acc_w    (ACW)
      ) u_lane (
         .clk        (clk),
         .rst        (rst),
         .hist_we    (h_we),
         .hist_waddr (hist_waddr),
         .hist_wdata (hist_wdata),
         .hist_raddr (rd_idx[DW-1:0]),
         .hist_rdata (hist_rd[l]),
         .ir_we      (c_we),
         .ir_waddr   (bus.i_ir_wr_addr[DW-1:0]),
         .ir_wdata   (bus.i_ir_wr_data),
         .ir_raddr   (cnt_q),
         .x          (x_op[l]),
         .acc_clr    (acc_clr),
         .acc_en     (acc_en),
         .acc        (acc[l])
      );
   end

   always_comb begin
      sum = '0;
      for (int l = 0; l < lanes; l++) begin
         sum = sum + SW'(acc[l]);
      end
   end

   assign bus.o_ready   = ready;
   assign bus.o_data    = o_data_q;
   assign bus.o_valid   = o_valid_q;
   assign bus.o_overrun = ovr_q;

endmodule

// File: tb/tb_fir_conv_tdm.sv
// tb_fir_conv_tdm: scenario tasks checked against a sum-of-products
// model of y[n] = sum h[k]*x[n-k], floor-shifted and saturated.
module tb_fir_conv_tdm;
   localparam int F = 16;
   localparam int N = 256;
   localparam int L = 4;
   localparam int D = N / L;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fir_conv_tdm_if #(.fxp_size(F), .window_size(N)) bus ();

   fir_conv_tdm #(
      .fxp_size    (F),
      .frac_size   (12),
      .window_size (N),
      .lanes       (L)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int passed = 0;
   int h_m [N];
   int xs [$];

   function automatic logic signed [15:0] model_y();
      longint s;
      int n;
      s = 0;
      n = xs.size() - 1;
      for (int k = 0; k < N; k++)
         if (n - k >= 0) s += longint'(h_m[k]) * longint'(xs[n - k]);
      s = s >>> 12;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return 16'(s);
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.i_valid = 1'b0;
      bus.i_ir_wr_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      xs.delete();
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (bus.o_ready !== 1'b1 && n < 4 * D) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic write_ir(input int k, input logic signed [15:0] v);
      int w;
      wait_ready(w);
      bus.i_ir_wr_en = 1'b1;
      bus.i_ir_wr_addr = 8'(k);
      bus.i_ir_wr_data = v;
      @(negedge clk);
      bus.i_ir_wr_en = 1'b0;
      h_m[k] = int'(v);
   endtask

   task automatic load_h();
      for (int k = 0; k < N; k++) write_ir(k, 16'(h_m[k]));
   endtask

   task automatic send(input logic signed [15:0] x, input logic b,
                       output logic signed [15:0] got, output int lat);
      int w;
      wait_ready(w);
      bus.i_data = x;
      bus.i_bypass = b;
      bus.i_valid = 1'b1;
      xs.push_back(int'(x));
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_bypass = 1'b0;
      lat = 0;
      while (bus.o_valid !== 1'b1 && lat < 4 * D) begin
         @(negedge clk);
         lat++;
      end
      got = bus.o_data;
   endtask

   task automatic test_reset();
      int n;
      do_reset();
      checks++;
      if (bus.o_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", bus.o_ready);
      else passed++;
      checks++;
      if (bus.o_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.o_valid);
      else passed++;
      checks++;
      if (bus.o_data !== 16'h0000) $display("FAIL reset_data got %h want 0000", bus.o_data);
      else passed++;
      checks++;
      if (bus.o_overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", bus.o_overrun);
      else passed++;
      wait_ready(n);
      checks++;
      if (n !== D) $display("FAIL clear_len got %0d want %0d", n, D);
      else passed++;
   endtask

   task automatic test_impulse();
      logic signed [15:0] xv [3];
      logic signed [15:0] ev [3];
      logic signed [15:0] got;
      int lat;
      xv[0] = 16'sh0400; xv[1] = 16'sh0000; xv[2] = 16'sh0000;
      ev[0] = 16'sh0400; ev[1] = 16'sh0200; ev[2] = 16'sh0000;
      do_reset();
      for (int k = 0; k < N; k++) h_m[k] = 0;
      h_m[0] = 4096;
      h_m[1] = 2048;
      load_h();
      for (int i = 0; i < 3; i++) begin
         send(xv[i], 1'b0, got, lat);
         checks++;
         if (got !== ev[i]) $display("FAIL impulse_%0d got %h want %h", i, got, ev[i]);
         else passed++;
         checks++;
         if (lat !== D + 2) $display("FAIL impulse_lat_%0d got %0d want %0d", i, lat, D + 2);
         else passed++;
      end
   endtask

   task automatic test_same_cycle();
      logic signed [15:0] exp_v;
      int w;
      int lat;
      wait_ready(w);
      bus.i_valid = 1'b1;
      bus.i_data = 16'sh0400;
      bus.i_ir_wr_en = 1'b1;
      bus.i_ir_wr_addr = 8'd0;
      bus.i_ir_wr_data = 16'sh2000;
      h_m[0] = 8192;
      xs.push_back(1024);
      exp_v = model_y();
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_ir_wr_en = 1'b0;
      lat = 0;
      while (bus.o_valid !== 1'b1 && lat < 4 * D) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (bus.o_data !== exp_v) $display("FAIL same_cycle got %h want %h", bus.o_data, exp_v);
      else passed++;
   endtask

   task automatic test_wrap();
      logic signed [15:0] got;
      logic signed [15:0] x;
      logic signed [15:0] exp_v;
      int lat;
      int bad;
      do_reset();
      for (int k = 0; k < N; k++) h_m[k] = 0;
      h_m[255] = 4096;
      load_h();
      bad = 0;
      for (int i = 0; i <= 300; i++) begin
         x = (i == 0) ? 16'sh0123 : 16'sh0000;
         send(x, 1'b0, got, lat);
         exp_v = model_y();
         checks++;
         if (got !== exp_v) begin
            if (bad < 5) $display("FAIL wrap_%0d got %h want %h", i, got, exp_v);
            bad++;
         end else passed++;
      end
   endtask

   task automatic test_saturation();
      logic signed [15:0] got;
      logic signed [15:0] exp_v;
      int lat;
      do_reset();
      for (int k = 0; k < N; k++) h_m[k] = (k < 4) ? 32767 : 0;
      load_h();
      for (int i = 0; i < 8; i++) begin
         send((i < 4) ? 16'sh7FFF : 16'sh8000, 1'b0, got, lat);
         exp_v = model_y();
         checks++;
         if (got !== exp_v) $display("FAIL sat_%0d got %h want %h", i, got, exp_v);
         else passed++;
      end
      checks++;
      if (got !== 16'sh8000) $display("FAIL sat_final got %h want 8000", got);
      else passed++;
   endtask

   task automatic test_bypass();
      logic signed [15:0] got;
      int lat;
      do_reset();
      for (int k = 0; k < N; k++) h_m[k] = 0;
      h_m[0] = 2048;
      load_h();
      send(16'sh0400, 1'b1, got, lat);
      checks++;
      if (got !== 16'sh0400) $display("FAIL bypass_data got %h want 0400", got);
      else passed++;
      checks++;
      if (lat !== D + 2) $display("FAIL bypass_lat got %0d want %0d", lat, D + 2);
      else passed++;
      send(16'sh0000, 1'b0, got, lat);
      checks++;
      if (got !== 16'sh0000) $display("FAIL bypass_off got %h want 0000", got);
      else passed++;
      write_ir(2, 16'sh1000);
      send(16'sh0000, 1'b0, got, lat);
      checks++;
      if (got !== model_y()) $display("FAIL bypass_hist got %h want %h", got, model_y());
      else passed++;
   endtask

   task automatic test_ir_overrun();
      logic signed [15:0] got;
      int w;
      int lat;
      do_reset();
      for (int k = 0; k < N; k++) h_m[k] = 0;
      h_m[0] = 4096;
      load_h();
      checks++;
      if (bus.o_overrun !== 1'b0) $display("FAIL ovr_clean got %b want 0", bus.o_overrun);
      else passed++;
      wait_ready(w);
      bus.i_valid = 1'b1;
      bus.i_data = 16'sh0400;
      xs.push_back(1024);
      @(negedge clk);
      bus.i_valid = 1'b0;
      bus.i_ir_wr_en = 1'b1;
      bus.i_ir_wr_addr = 8'd0;
      bus.i_ir_wr_data = 16'sh7FFF;
      @(negedge clk);
      bus.i_ir_wr_en = 1'b0;
      lat = 1;
      while (bus.o_valid !== 1'b1 && lat < 4 * D) begin
         @(negedge clk);
         lat++;
      end
      checks++;
      if (bus.o_data !== model_y()) $display("FAIL ovr_data got %h want %h", bus.o_data, model_y());
      else passed++;
      checks++;
      if (bus.o_overrun !== 1'b1) $display("FAIL ovr_flag got %b want 1", bus.o_overrun);
      else passed++;
      send(16'sh0200, 1'b0, got, lat);
      checks++;
      if (got !== model_y()) $display("FAIL ovr_h_kept got %h want %h", got, model_y());
      else passed++;
   endtask

   task automatic test_backpressure();
      logic signed [15:0] exp_q [$];
      logic signed [15:0] got_q [$];
      logic signed [15:0] d;
      int acc_n;
      int w;
      int cyc;
      do_reset();
      for (int k = 0; k < N; k++)
         h_m[k] = (k < 8) ? int'($urandom_range(0, 1023)) - 512 : 0;
      load_h();
      wait_ready(w);
      acc_n = 0;
      cyc = 3 * (D + 3) + 5;
      for (int c = 0; c < cyc; c++) begin
         d = 16'($urandom);
         bus.i_valid = 1'b1;
         bus.i_data = d;
         if (bus.o_valid === 1'b1) got_q.push_back(bus.o_data);
         if (bus.o_ready === 1'b1) begin
            xs.push_back(int'(d));
            exp_q.push_back(model_y());
            acc_n++;
         end
         @(negedge clk);
      end
      bus.i_valid = 1'b0;
      for (int c = 0; c < 2 * D + 8; c++) begin
         if (bus.o_valid === 1'b1) got_q.push_back(bus.o_data);
         @(negedge clk);
      end
      checks++;
      if (acc_n !== (cyc + D + 1) / (D + 2))
         $display("FAIL bp_accepts got %0d want %0d", acc_n, (cyc + D + 1) / (D + 2));
      else passed++;
      checks++;
      if (got_q.size() !== acc_n) $display("FAIL bp_count got %0d want %0d", got_q.size(), acc_n);
      else passed++;
      checks++;
      if (bus.o_overrun !== 1'b1) $display("FAIL bp_overrun got %b want 1", bus.o_overrun);
      else passed++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (got_q[i] !== exp_q[i]) $display("FAIL bp_data_%0d got %h want %h", i, got_q[i], exp_q[i]);
         else passed++;
      end
   endtask

   task automatic test_reset_mid();
      logic signed [15:0] got;
      logic seen;
      int n;
      int w;
      int lat;
      wait_ready(w);
      bus.i_valid = 1'b1;
      bus.i_data = 16'sh0555;
      @(negedge clk);
      bus.i_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      xs.delete();
      checks++;
      if (bus.o_data !== 16'h0000) $display("FAIL mid_data got %h want 0000", bus.o_data);
      else passed++;
      checks++;
      if (bus.o_overrun !== 1'b0) $display("FAIL mid_overrun got %b want 0", bus.o_overrun);
      else passed++;
      n = 0;
      seen = 1'b0;
      while (bus.o_ready !== 1'b1 && n < 4 * D) begin
         if (bus.o_valid === 1'b1) seen = 1'b1;
         @(negedge clk);
         n++;
      end
      repeat (8) begin
         if (bus.o_valid === 1'b1) seen = 1'b1;
         @(negedge clk);
      end
      checks++;
      if (n + 1 !== D + 1) $display("FAIL mid_busy got %0d want %0d", n + 1, D + 1);
      else passed++;
      checks++;
      if (seen !== 1'b0) $display("FAIL mid_valid got %b want 0", seen);
      else passed++;
      send(16'sh0300, 1'b0, got, lat);
      checks++;
      if (got !== model_y()) $display("FAIL mid_ir_kept got %h want %h", got, model_y());
      else passed++;
   endtask

   task automatic test_random();
      logic signed [15:0] got;
      logic signed [15:0] x;
      logic signed [15:0] exp_v;
      logic b;
      int lat;
      do_reset();
      for (int k = 0; k < N; k++) h_m[k] = int'($urandom_range(0, 1023)) - 512;
      load_h();
      for (int i = 0; i < 24; i++) begin
         x = 16'($urandom);
         b = ($urandom_range(0, 3) == 0);
         send(x, b, got, lat);
         exp_v = b ? x : model_y();
         checks++;
         if (got !== exp_v) $display("FAIL rand_%0d got %h want %h", i, got, exp_v);
         else passed++;
         checks++;
         if (lat !== D + 2) $display("FAIL rand_lat_%0d got %0d want %0d", i, lat, D + 2);
         else passed++;
      end
   endtask

   initial begin
      bus.i_data = '0;
      bus.i_valid = 1'b0;
      bus.i_bypass = 1'b0;
      bus.i_ir_wr_en = 1'b0;
      bus.i_ir_wr_addr = '0;
      bus.i_ir_wr_data = '0;
      test_reset();
      test_impulse();
      test_same_cycle();
      test_wrap();
      test_saturation();
      test_bypass();
      test_ir_overrun();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/fir_conv_tdm.md
Name: fir_conv_tdm

Overview:
Time-multiplexed direct-form FIR convolver for cabinet/impulse-response simulation in the effects chain. It is the parametrised successor of the fixed-window overlap-add IR block. It adds a run-time-loadable IR memory, configurable MAC lane count, a circular sample history, a bypass mode with matched latency, and a ready/valid input handshake. It sits between the pre-amp/distortion stage and the output DAC path at audio sample rate, running many clocks per sample.

Parameters:
fxp_size, 16, signed fixed-point word width (samples and coefficients)
frac_size, 12, fractional bits of every fixed-point word
window_size, 256, number of IR taps N; power of two, >= lanes
lanes, 4, parallel MAC lanes; power of two dividing window_size; D = window_size/lanes cycles per sample

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
i_data  in  fxp_size  input sample, signed
i_valid  in  1  input sample strobe
o_ready  out  1  block can accept a sample or IR write this cycle
i_bypass  in  1  sampled with each accepted input; 1 = pass dry sample
i_ir_wr_en  in  1  IR coefficient write strobe
i_ir_wr_addr  in  $clog2(window_size)  tap index k
i_ir_wr_data  in  fxp_size  coefficient h[k], signed
o_data  out  fxp_size  output sample, signed
o_valid  out  1  one-cycle strobe, o_data valid
o_overrun  out  1  sticky: a sample or IR write was presented while o_ready=0

Behaviour:
- Reset (rst=1 at a clock edge): state CLEAR, o_ready=0, o_valid=0, o_data=0, o_overrun=0, wr_ptr=0, accumulators=0. The IR memory is NOT reset; its contents are retained.
- CLEAR: writes zero to every history entry, lanes entries per cycle, over D cycles. Then moves to IDLE. rst asserted during any state restarts CLEAR; an in-flight sample produces no o_valid.
- IDLE: o_ready=1.
  - i_valid: write i_data to history[wr_ptr], latch i_bypass, clear accumulators, go to ACCUM.
  - i_ir_wr_en alone: write h[addr] this cycle.
  - i_valid and i_ir_wr_en in the same cycle: both take effect; the new coefficient is used for this sample.
- ACCUM: o_ready=0. For D cycles, lane l at step j computes tap k = l*D + j: acc_l += h[k] * history[(wr_ptr - k) mod window_size]. Pointer arithmetic wraps modulo window_size. Then go to ROUND.
- ROUND: one cycle.
  - Sum lane accumulators, arithmetic shift right by frac_size with truncation toward negative infinity, saturate to [-2^(fxp_size-1), 2^(fxp_size-1)-1].
  - If bypass was latched, o_data = the accepted input sample instead.
  - Pulse o_valid, wr_ptr += 1 (wraps), return to IDLE.
- Result: y[n] = sum over k=0..N-1 of h[k]*x[n-k]. x before the first accepted sample after reset is 0.
- Latency: o_valid asserts exactly D+2 clocks after the accepting edge. o_data holds until the next o_valid.
- Bypass still writes history, so switching back is glitch-free.
- i_valid or i_ir_wr_en while o_ready=0: ignored (sample/write dropped) and o_overrun sets. It stays set until rst.
- Widths:
  - Product: 2*fxp_size bits.
  - Lane accumulator: 2*fxp_size + $clog2(D) bits.
  - Final sum: 2*fxp_size + $clog2(window_size) bits.
  - No internal overflow is possible.
- History and IR storage: lanes banks of depth D each, so each lane reads one entry per cycle (RAM-inferable).

Decomposition:
- Package fir_conv_pkg:
  - state enum {CLEAR, IDLE, ACCUM, ROUND}
  - localparam functions for acc widths and D
  - saturate-and-shift function
- Sub-module fir_mac_lane holds one bank pair (history + IR slice) and one accumulator. It is instantiated lanes times via generate. The top holds the FSM, pointers, reduction and rounding.

Test Plan:
- Impulse, 2-tap IR: h[0]=0x1000, h[1]=0x0800, rest 0; feed 0x0400, 0, 0 -> o_data 0x0400, 0x0200, 0x0000. Each output comes D+2 clocks after acceptance.
- Last-tap wrap: h[255]=0x1000 only; feed 0x0123 then 300 zeros -> output 0x0123 on the 256th sample (n=255), zero elsewhere, with wr_ptr crossing 255->0.
- Saturation: h[0..3]=0x7FFF; feed 0x7FFF x4 -> final 0x7FFF. With 0x8000 inputs -> 0x8000.
- Backpressure: assert i_valid every cycle -> accepted only when o_ready=1, o_overrun=1, output count = accepted count.
- Bypass: h[0]=0x0800, i_bypass=1, feed 0x0400 -> 0x0400 after D+2. Then bypass=0, feed 0 -> 0x0000 (history intact: h[1]=0 case).
- Reset mid-ACCUM: rst one cycle during ACCUM -> no o_valid, o_ready=0 for D+1 cycles, o_data=0. Coefficients are still applied to the next sample.
